// File: rtl/vga_pkg.sv
// Shared definitions for the VGA sprite path: default timing origin,
// the scale encoding and the 3-bit colour type.
package vga_pkg;

  localparam int H_START_DEF = 216;
  localparam int V_START_DEF = 27;

  typedef enum logic [1:0] {
    SCALE_1X     = 2'd0,
    SCALE_2X     = 2'd1,
    SCALE_4X     = 2'd2,
    SCALE_4X_ALT = 2'd3
  } scale_e;

  typedef logic [2:0] color_t;

  // Replication factor expressed as a left-shift amount.
  function automatic logic [1:0] scale_shift(input scale_e sc);
    case (sc)
      SCALE_1X: scale_shift = 2'd0;
      SCALE_2X: scale_shift = 2'd1;
      default:  scale_shift = 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register used to keep per-pixel attributes aligned
// with the ROM read data.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // NOTE: every stage is reset, not just the head; the valid flags riding in
  // here must not release stale pixels after a mid-frame reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_sprite_ctrl.sv
// 1bpp sprite overlay: window test, ROM addressing and colour mux in a
// fixed 3+ROM_LAT stage pipeline running at one pixel per clock.
module vga_sprite_ctrl
  import vga_pkg::*;
#(
  parameter int SPR_W   = 128,
  parameter int SPR_H   = 128,
  parameter int H_START = H_START_DEF,
  parameter int V_START = V_START_DEF,
  parameter int ROM_LAT = 1,
  parameter int ADDR_W  = $clog2(SPR_W * SPR_H / 8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       c1,
  input  logic [10:0]       c2,
  input  logic [10:0]       pos_x,
  input  logic [10:0]       pos_y,
  input  logic              pos_wr,
  input  logic [1:0]        scale,
  input  color_t            fg_color,
  input  color_t            bg_color,
  input  logic              transp,
  input  color_t            under_rgb,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output color_t            rgb,
  output logic              sprite_hit
);

  localparam int XW = $clog2(SPR_W);
  localparam int YW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  logic [10:0] pend_x_q, pend_y_q, ax_q, ay_q;
  logic [1:0]  shift_q;
  logic        frame_start;

  assign frame_start = (c1 == 11'd0) && (c2 == 11'd0);

  // Offset and scale only change at frame start so a frame is never torn.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_x_q <= '0;
      pend_y_q <= '0;
      ax_q     <= '0;
      ay_q     <= '0;
      shift_q  <= '0;
    end else begin
      if (pos_wr) begin
        pend_x_q <= pos_x;
        pend_y_q <= pos_y;
      end
      if (frame_start) begin
        ax_q    <= pos_wr ? pos_x : pend_x_q;
        ay_q    <= pos_wr ? pos_y : pend_y_q;
        shift_q <= scale_shift(scale_e'(scale));
      end
    end
  end

  // Stage 0: window test, done 13 bits wide so the upper bound cannot overflow.
  logic [12:0]   lo_x, lo_y, off_x, off_y;
  logic          in_x, in_y, v0_d, v0_q;
  logic [XW-1:0] xr_d, xr_q;
  logic [YW-1:0] yr_d, yr_q;

  // NOTE: all always_comb outputs get a default first so no latch is inferred.
  always_comb begin
    lo_x  = 13'(H_START) + {2'b00, ax_q};
    lo_y  = 13'(V_START) + {2'b00, ay_q};
    off_x = {2'b00, c1} - lo_x - 13'd1;
    off_y = {2'b00, c2} - lo_y - 13'd1;
    in_x  = ({2'b00, c1} > lo_x) && ({2'b00, c1} <= lo_x + (13'(SPR_W) << shift_q));
    in_y  = ({2'b00, c2} > lo_y) && ({2'b00, c2} <= lo_y + (13'(SPR_H) << shift_q));
    v0_d  = in_x && in_y;
    xr_d  = '0;
    yr_d  = '0;
    if (v0_d) begin
      xr_d = XW'(off_x >> shift_q);
      yr_d = YW'(off_y >> shift_q);
    end
  end

  logic [ADDR_W-1:0] addr_d, rom_addr_q;
  logic [2:0]        bit_q;
  logic              v1_q;

  assign addr_d = ADDR_W'(yr_q) * ADDR_W'(SPR_W / 8) + ADDR_W'(xr_q >> 3);

  // NOTE: state registers use non-blocking assignments so every stage samples
  // the previous stage's pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q       <= 1'b0;
      xr_q       <= '0;
      yr_q       <= '0;
      v1_q       <= 1'b0;
      bit_q      <= '0;
      rom_addr_q <= '0;
    end else begin
      v0_q       <= v0_d;
      xr_q       <= xr_d;
      yr_q       <= yr_d;
      v1_q       <= v0_q;
      bit_q      <= xr_q[2:0];
      rom_addr_q <= addr_d;
    end
  end

  assign rom_addr = rom_addr_q;

  logic [3:0] pix_dly;
  logic       v2;
  logic [2:0] bit2;
  logic [9:0] attr_dly;
  logic       transp_a;
  color_t     fg_a, bg_a, under_a;

  vga_delay_line #(.WIDTH(4), .DEPTH(ROM_LAT)) u_pix_dly (
    .clk (clk),
    .rst (rst),
    .d_i ({v1_q, bit_q}),
    .q_o (pix_dly)
  );

  // Attributes enter with c1/c2, so they wait for both pipeline stages too.
  vga_delay_line #(.WIDTH(10), .DEPTH(ROM_LAT + 2)) u_attr_dly (
    .clk (clk),
    .rst (rst),
    .d_i ({transp, fg_color, bg_color, under_rgb}),
    .q_o (attr_dly)
  );

  assign {v2, bit2}                     = pix_dly;
  assign {transp_a, fg_a, bg_a, under_a} = attr_dly;

  color_t rgb_d, rgb_q;
  logic   hit_q;

  always_comb begin
    rgb_d = under_a;
    if (v2) begin
      if (rom_data[bit2]) rgb_d = fg_a;
      else if (!transp_a) rgb_d = bg_a;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q <= '0;
      hit_q <= 1'b0;
    end else begin
      rgb_q <= rgb_d;
      hit_q <= v2;
    end
  end

  assign rgb        = rgb_q;
  assign sprite_hit = hit_q;

endmodule

// File: tb/tb_vga_sprite_ctrl.sv
// Bench for vga_sprite_ctrl: ROM_LAT=1 and ROM_LAT=3 instances driven in
// parallel and compared against an arithmetic model of the sprite window.
module tb_vga_sprite_ctrl;

  localparam int SPR_W = 128;
  localparam int SPR_H = 128;
  localparam int HS    = 216;
  localparam int VS    = 27;
  localparam int NMAX  = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] c1, c2, pos_x, pos_y;
  logic        pos_wr, transp;
  logic [1:0]  scale;
  logic [2:0]  fg, bg, under;

  logic [10:0] addr1, addr3;
  logic [7:0]  rd1, rd3;
  logic [2:0]  rgb1, rgb3;
  logic        hit1, hit3;

  logic [7:0]  rom [0:2047];
  logic [7:0]  p1;
  logic [7:0]  p3 [0:2];

  always #5 clk = ~clk;

  // ROM models with one and three clocks of read latency.
  always @(posedge clk) begin
    p1    <= rom[addr1];
    p3[0] <= rom[addr3];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign rd1 = p1;
  assign rd3 = p3[2];

  vga_sprite_ctrl #(.ROM_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .c1(c1), .c2(c2), .pos_x(pos_x), .pos_y(pos_y),
    .pos_wr(pos_wr), .scale(scale), .fg_color(fg), .bg_color(bg),
    .transp(transp), .under_rgb(under), .rom_addr(addr1), .rom_data(rd1),
    .rgb(rgb1), .sprite_hit(hit1)
  );

  vga_sprite_ctrl #(.ROM_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .c1(c1), .c2(c2), .pos_x(pos_x), .pos_y(pos_y),
    .pos_wr(pos_wr), .scale(scale), .fg_color(fg), .bg_color(bg),
    .transp(transp), .under_rgb(under), .rom_addr(addr3), .rom_data(rd3),
    .rgb(rgb3), .sprite_hit(hit3)
  );

  int checks = 0;
  int fails  = 0;
  int n      = 0;
  int ax_m, ay_m, s_m, px_m, py_m;
  logic [3:0]  exp1 [NMAX];
  logic [3:0]  exp3 [NMAX];
  logic [10:0] exp_a [NMAX];

  logic        m_hit;
  logic [2:0]  m_rgb;
  int          m_addr;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s edge %0d: observed %h expected %h", tag, n, obs, expv);
    end
  endtask

  // Pixel the spec predicts for the inputs currently on the pins.
  function automatic void ref_eval();
    int w, h, lox, loy, xr, yr, cx, cy;
    logic [7:0] byte_v;
    cx  = int'(c1);
    cy  = int'(c2);
    w   = SPR_W << s_m;
    h   = SPR_H << s_m;
    lox = HS + ax_m;
    loy = VS + ay_m;
    if (cx > lox && cx <= lox + w && cy > loy && cy <= loy + h) begin
      xr     = (cx - lox - 1) >> s_m;
      yr     = (cy - loy - 1) >> s_m;
      m_addr = yr * (SPR_W / 8) + xr / 8;
      byte_v = rom[m_addr];
      m_hit  = 1'b1;
      m_rgb  = byte_v[xr % 8] ? fg : (transp ? under : bg);
    end else begin
      m_addr = 0;
      m_hit  = 1'b0;
      m_rgb  = under;
    end
  endfunction

  task automatic step();
    if (rst) begin
      for (int k = 1; k <= 4; k++) exp1[n+k] = 4'h0;
      for (int k = 1; k <= 6; k++) exp3[n+k] = 4'h0;
      for (int k = 1; k <= 2; k++) exp_a[n+k] = 11'd0;
      ax_m = 0; ay_m = 0; s_m = 0; px_m = 0; py_m = 0;
    end else begin
      ref_eval();
      exp1[n+4]  = {m_hit, m_rgb};
      exp3[n+6]  = {m_hit, m_rgb};
      exp_a[n+2] = 11'(m_addr);
      if (c1 == 11'd0 && c2 == 11'd0) begin
        ax_m = pos_wr ? int'(pos_x) : px_m;
        ay_m = pos_wr ? int'(pos_y) : py_m;
        s_m  = (scale == 2'd0) ? 0 : (scale == 2'd1) ? 1 : 2;
      end
      if (pos_wr) begin
        px_m = int'(pos_x);
        py_m = int'(pos_y);
      end
    end
    @(posedge clk);
    n++;
    #1;
    check("out_lat1", {12'h0, hit1, rgb1}, {12'h0, exp1[n]});
    check("out_lat3", {12'h0, hit3, rgb3}, {12'h0, exp3[n]});
    check("addr_lat1", {5'h0, addr1}, {5'h0, exp_a[n]});
    check("addr_lat3", {5'h0, addr3}, {5'h0, exp_a[n]});
  endtask

  task automatic drive(input int a, input int b);
    c1    = 11'(a);
    c2    = 11'(b);
    under = 3'($urandom);
    step();
  endtask

  initial begin
    for (int i = 0; i < NMAX; i++) begin
      exp1[i] = 4'h0; exp3[i] = 4'h0; exp_a[i] = 11'd0;
    end
    for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
    rom[0]  = 8'h01;
    rom[15] = 8'h80;
    ax_m = 0; ay_m = 0; s_m = 0; px_m = 0; py_m = 0;
    rst = 1'b1; pos_x = '0; pos_y = '0; pos_wr = 1'b0; scale = 2'd0;
    fg = 3'd5; bg = 3'd2; transp = 1'b0; c1 = 11'd2047; c2 = 11'd2047; under = 3'd0;

    // Reset state
    for (int i = 0; i < 3; i++) drive(2047, 2047);
    check("rst_rgb", {13'h0, rgb1}, 16'h0);
    check("rst_hit", {15'h0, hit1}, 16'h0);
    check("rst_addr", {5'h0, addr1}, 16'h0);
    rst = 1'b0;

    // Origin, 1x: first pixel, right edge and just-outside columns
    drive(0, 0);
    drive(215, 28);
    drive(216, 28);
    drive(217, 28);
    drive(218, 28);
    check("addr_first", {5'h0, addr1}, 16'd0);
    drive(219, 28);
    drive(220, 28);
    check("rgb_first", {12'h0, hit1, rgb1}, {12'h0, 1'b1, 3'd5});
    for (int x = 221; x <= 343; x++) drive(x, 28);
    drive(344, 28);
    drive(345, 28);
    check("addr_last_col", {5'h0, addr1}, 16'd15);
    for (int x = 346; x <= 350; x++) drive(x, 28);

    // Shadowed position write takes effect only at the next frame start
    pos_x = 11'd100; pos_y = 11'd50; pos_wr = 1'b1;
    drive(500, 28);
    pos_wr = 1'b0; pos_x = '0; pos_y = '0;
    for (int x = 210; x <= 230; x++) drive(x, 28);
    drive(0, 0);
    for (int x = 314; x <= 320; x++) drive(x, 77);
    drive(317, 78);
    drive(318, 78);
    drive(319, 78);
    drive(320, 78);
    check("moved_first_hit", {15'h0, hit1}, 16'h1);
    for (int x = 314; x <= 318; x++) drive(x, 78);

    // 2x, position written on the frame-start cycle itself
    scale = 2'd1; pos_x = '0; pos_y = '0; pos_wr = 1'b1;
    drive(0, 0);
    pos_wr = 1'b0;
    foreach (rom[i]) begin end
    for (int yi = 0; yi < 5; yi++) begin
      automatic int yy = (yi == 0) ? 28 : (yi == 1) ? 29 : (yi == 2) ? 283 : (yi == 3) ? 284 : 150;
      for (int x = 215; x <= 220; x++) drive(x, yy);
      for (int x = 470; x <= 476; x++) drive(x, yy);
    end

    // Transparent sprite over the underlay, with a reset mid-window
    scale = 2'd0; transp = 1'b1;
    drive(0, 0);
    for (int i = 0; i < 8; i++) drive(2047, 2047);
    for (int i = 0; i < 2048; i++) rom[i] = 8'h00;
    for (int x = 210; x <= 259; x++) drive(x, 40);
    rst = 1'b1;
    drive(260, 40);
    rst = 1'b0;
    check("midrst_rgb", {13'h0, rgb1}, 16'h0);
    check("midrst_hit", {15'h0, hit1}, 16'h0);
    for (int x = 261; x <= 350; x++) drive(x, 40);

    // Randomised traffic
    for (int i = 0; i < 8; i++) drive(2047, 2047);
    for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
    for (int i = 0; i < 900; i++) begin
      fg     = 3'($urandom);
      bg     = 3'($urandom);
      transp = 1'($urandom);
      pos_wr = ($urandom % 16) == 0;
      pos_x  = ($urandom % 8 == 0) ? 11'($urandom) : 11'($urandom_range(0, 700));
      pos_y  = ($urandom % 8 == 0) ? 11'($urandom) : 11'($urandom_range(0, 500));
      rst    = ($urandom % 150) == 0;
      if ($urandom % 40 == 0) begin
        scale = 2'($urandom);
        drive(0, 0);
      end else if ($urandom % 8 == 0) begin
        drive(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)));
      end else begin
        drive(int'($urandom_range(150, 1200)), int'($urandom_range(0, 700)));
      end
    end
    rst = 1'b0; pos_wr = 1'b0;
    for (int i = 0; i < 8; i++) drive(2047, 2047);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/vga_sprite_ctrl.md
VGA_SPRITE_CTRL -- requirements
Module: vga_sprite_ctrl

Interface
REQ-001 Parameter SPR_W, default 128: sprite width in source pixels; power of two, minimum 8.
REQ-002 Parameter SPR_H, default 128: sprite height in source lines.
REQ-003 Parameter H_START, default 216: first active c1 value minus 1 (sync plus back porch).
REQ-004 Parameter V_START, default 27: first active c2 value minus 1.
REQ-005 Parameter ROM_LAT, default 1, range 1..3: ROM read latency in clocks.
REQ-006 Parameter ADDR_W, default clog2(SPR_W*SPR_H/8): ROM address width.
REQ-007 Port clk, input, 1: single clock; every register is updated on its rising edge.
REQ-008 Port rst, input, 1: synchronous, active-high reset.
REQ-009 Ports c1 and c2, input, 11 each: horizontal and vertical counters from the sync generator.
REQ-010 Ports pos_x and pos_y, input, 11 each: requested sprite offset from the active origin.
REQ-011 Port pos_wr, input, 1: one-cycle strobe that captures pos_x and pos_y.
REQ-012 Port scale, input, 2: pixel replication; 0 = 1x, 1 = 2x, 2 = 4x, 3 = treated as 4x.
REQ-013 Ports fg_color and bg_color, input, 3 each: colours shown for bit 1 and for bit 0.
REQ-014 Port transp, input, 1: when 1, bit-0 pixels show under_rgb instead of bg_color.
REQ-015 Port under_rgb, input, 3: underlay pixel, aligned with c1/c2.
REQ-016 Port rom_addr, output, ADDR_W: byte address into the 1bpp sprite ROM.
REQ-017 Port rom_data, input, 8: ROM byte, valid ROM_LAT clocks after rom_addr.
REQ-018 Port rgb, output, 3: final pixel.
REQ-019 Port sprite_hit, output, 1: high when rgb comes from the sprite window; aligned with rgb.

Function
REQ-020 Shadow offset: pos_wr loads pend_x/pend_y; active offset loads from pend_x/pend_y when c1==0 and c2==0 (frame start).
REQ-021 If pos_wr coincides with frame start, the active offset takes pos_x/pos_y directly (write bypass).
REQ-022 scale is sampled into the active scale register at frame start only.
REQ-023 Window test (stage 0) uses 13-bit unsigned arithmetic, so no intermediate overflows:
  - horizontal: H_START+ax < c1 <= H_START+ax+(SPR_W<<s)
  - vertical: V_START+ay < c2 <= V_START+ay+(SPR_H<<s)
REQ-024 Parts of the window beyond the counter range are not displayed (clipped); no wrap-around to the opposite edge.
REQ-025 Stage 0 registers the following; outside the window xr, yr and valid are 0:
  - xr = (c1-H_START-ax-1)>>s
  - yr = (c2-V_START-ay-1)>>s
  - valid
REQ-026 Stage 1 registers:
  - rom_addr = yr*(SPR_W/8) + xr/8
  - bit index = xr[2:0]
  - valid
REQ-027 Bit index, valid, transp, fg_color, bg_color and under_rgb are delayed so they align with rom_data.
REQ-028 Bit xr[2:0] of rom_data is the pixel; bit 0 is the leftmost pixel.
REQ-029 Output stage registers rgb and sprite_hit:
  - valid and pixel 1: fg_color
  - valid, pixel 0, transp 0: bg_color
  - valid, pixel 0, transp 1: under_rgb
  - not valid: under_rgb, and sprite_hit=0
REQ-030 Total latency from c1/c2 to rgb is 3+ROM_LAT clocks, including when the window is not hit.
REQ-031 Throughput is one pixel per clock with no stalls.

Reset
REQ-032 While rst is high, the following are 0 on the next edge:
  - rgb, sprite_hit and rom_addr
  - all pipeline valids
  - pend_x, pend_y and the active offset
  - active scale
REQ-033 Reset mid-frame: the first non-black output comes only after new valid data has traversed the full pipeline; stale ROM data never reaches rgb.

Structure
REQ-034 A shared package vga_pkg holds:
  - the default timing constants H_START and V_START
  - the scale encoding
  - the 3-bit colour type
REQ-035 Sub-module vga_delay_line (parametrised width and depth, synchronous reset) implements the alignment delays of REQ-027.

Verification
REQ-036 Defaults, pos (0,0), scale 0, ROM byte0=0x01, c1=217, c2=28 -> rom_addr=0 after 2 clocks; rgb=fg_color 4 clocks after c1/c2.
REQ-037 c1=216 or c1=345 at c2=28 -> sprite_hit=0 and rgb=under_rgb; c1=344 -> rom_addr=15, bit 7.
REQ-038 pos_wr with (100,50) mid-frame -> output unchanged until the next c1=c2=0; next frame's first hit is at c1=317, c2=78.
REQ-039 scale=1 -> window 256x256; c1=217 and c1=218 both read xr=0; c2=283 is the last hit line.
REQ-040 transp=1, ROM all zeros -> rgb equals under_rgb delayed 4 clocks; sprite_hit=1 inside the window.
REQ-041 Assert rst for one clock mid-window -> rgb=0 and sprite_hit=0 next edge; the pipeline refills within 4 clocks; ROM_LAT=3 run gives latency 6.
